// File: rtl/sr_cmd_arbiter_if.sv
// Command handshake bundle for the two requesters of sr_cmd_arbiter.
// The requester side uses the master modport; the arbiter uses the slave modport.
interface sr_cmd_arbiter_if #(
    parameter int NFLAGS = 8,
    parameter int IW     = (NFLAGS > 1) ? $clog2(NFLAGS) : 1
);
    logic          a_valid;
    logic [1:0]    a_op;
    logic [IW-1:0] a_idx;
    logic          a_ready;
    logic          b_valid;
    logic [1:0]    b_op;
    logic [IW-1:0] b_idx;
    logic          b_ready;

    modport master (
        output a_valid, a_op, a_idx, b_valid, b_op, b_idx,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_op, a_idx, b_valid, b_op, b_idx,
        output a_ready, b_ready
    );
endinterface

// File: rtl/sr_cmd_arbiter.sv
// Two-port round-robin arbiter applying SET/CLR/TOGGLE commands to a bank of SR flags,
// with one-cycle set/reset strobes and a saturating count of applied commands.
module sr_cmd_arbiter #(
    parameter int NFLAGS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_cmd_arbiter_if.slave    cmd,
    output logic [NFLAGS-1:0]  q,
    output logic [NFLAGS-1:0]  q_bar,
    output logic [NFLAGS-1:0]  s_strb,
    output logic [NFLAGS-1:0]  r_strb,
    output logic [7:0]         ops_cnt
);
    localparam int IW = (NFLAGS > 1) ? $clog2(NFLAGS) : 1;
    localparam logic [IW:0] NF = (IW + 1)'(NFLAGS);

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;
    typedef enum logic [1:0] {OP_NOP = 2'b00, OP_CLR = 2'b01, OP_SET = 2'b10, OP_TOG = 2'b11} op_t;

    port_t             rr_last;
    port_t             rr_next;
    logic              grant_a;
    logic              grant_b;
    logic              xfer;
    logic              idx_ok;
    logic              apply;
    logic              old_bit;
    logic              set_now;
    logic              clr_now;
    op_t               sel_op;
    logic [IW-1:0]     sel_idx;
    logic [NFLAGS-1:0] onehot;
    logic [NFLAGS-1:0] q_next;

    // Round-robin pointer: reset leaves B as last winner so A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= PORT_B;
        end else begin
            rr_last <= rr_next;
        end
    end

    always_comb begin
        rr_next = rr_last;
        if (grant_a) begin
            rr_next = PORT_A;
        end else if (grant_b) begin
            rr_next = PORT_B;
        end
    end

    always_comb begin
        grant_a     = cmd.a_valid && (!cmd.b_valid || rr_last == PORT_B);
        grant_b     = cmd.b_valid && !grant_a;
        cmd.a_ready = grant_a;
        cmd.b_ready = grant_b;
    end

    // Out-of-range indices behave as NOP; a shifted-out one-hot keeps old_bit safe for them.
    always_comb begin
        xfer    = grant_a || grant_b;
        sel_op  = grant_a ? op_t'(cmd.a_op) : op_t'(cmd.b_op);
        sel_idx = grant_a ? cmd.a_idx : cmd.b_idx;
        idx_ok  = {1'b0, sel_idx} < NF;
        onehot  = NFLAGS'(1) << sel_idx;
        apply   = xfer && idx_ok && (sel_op != OP_NOP);
        old_bit = |(q & onehot);
        set_now = apply && ((sel_op == OP_SET) || ((sel_op == OP_TOG) && !old_bit));
        clr_now = apply && !set_now;
        q_next  = q;
        if (set_now) begin
            q_next = q | onehot;
        end else if (clr_now) begin
            q_next = q & ~onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            s_strb  <= '0;
            r_strb  <= '0;
            ops_cnt <= 8'd0;
        end else begin
            q       <= q_next;
            s_strb  <= set_now ? onehot : '0;
            r_strb  <= clr_now ? onehot : '0;
            if (apply && (ops_cnt != 8'hFF)) begin
                ops_cnt <= ops_cnt + 8'd1;
            end
        end
    end

    assign q_bar = ~q;
endmodule

// File: doc/sr_cmd_arbiter.md
SR_CMD_ARBITER -- requirements
Module: sr_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter NFLAGS, default 8, meaning the number of SR flags held (index width IW = 3 for the default).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports a_valid, b_valid  input  1 each  command present on requester A / B.
REQ-005 The block SHALL have ports a_op, b_op  input  2 each  command code: 00 NOP, 01 CLR, 10 SET, 11 TOGGLE.
REQ-006 The block SHALL have ports a_idx, b_idx  input  IW each  target flag index.
REQ-007 The block SHALL have ports a_ready, b_ready  output  1 each  grant; a transfer occurs when valid and ready are both high.
REQ-008 The block SHALL have port q  output  NFLAGS  registered flag states.
REQ-009 The block SHALL have port q_bar  output  NFLAGS  bitwise inverse of q at all times.
REQ-010 The block SHALL have ports s_strb, r_strb  output  NFLAGS each  registered one-cycle set/reset strobes of the last applied command.
REQ-011 The block SHALL have port ops_cnt  output  8  saturating count of applied non-NOP commands.

Function
REQ-012 Grant SHALL be combinational from valid inputs and rr_last: only A valid -> a_ready=1; only B valid -> b_ready=1; both valid -> grant the port not equal to rr_last; neither valid -> both ready low.
REQ-013 At most one of a_ready, b_ready SHALL be high in any cycle.
REQ-014 rr_last SHALL update to the granted port on every transfer, including NOP transfers.
REQ-015 A transferred command SHALL take effect on q at the same clock edge (q reflects it in the next cycle; latency 1).
REQ-016 SET SHALL force q[idx]=1, CLR force q[idx]=0, TOGGLE invert q[idx], NOP leave q unchanged; all other bits hold.
REQ-017 s_strb/r_strb SHALL be one-hot on idx for one cycle after SET (s) or CLR (r); for TOGGLE, s if old q[idx]=0, else r; all-zero after NOP or no transfer.
REQ-018 s_strb[i] and r_strb[i] SHALL never both be 1 (the S=R=1 illegal case is unreachable by construction).
REQ-019 When both ports target the same index in one cycle, only the granted command SHALL apply; the loser holds valid and is granted next cycle, applying against the updated q.
REQ-020 Requesters SHALL hold op/idx stable while valid and not ready; the block need not check this.
REQ-021 idx >= NFLAGS (non-default NFLAGS only) SHALL be accepted and treated as NOP (no q change, no strobe, no count).
REQ-022 ops_cnt SHALL increment by 1 per applied SET/CLR/TOGGLE and saturate at 255 (no wrap).

Reset
REQ-023 While rst_n=0: q=0, q_bar=all ones, s_strb=0, r_strb=0, ops_cnt=0, rr_last=B (A wins first contention); ready outputs still follow REQ-012 combinationally but no transfer is applied.
REQ-024 Reset asserted mid-operation SHALL discard any in-flight command; first transfer after deassertion is applied normally at the next rising edge.

Verification
REQ-025 After reset, A: SET idx 3 alone -> a_ready=1; next cycle q=0x08, q_bar=0xF7, s_strb=0x08, ops_cnt=1.
REQ-026 Both valid, A SET idx 1, B CLR idx 2 from q=0x04 -> cycle 1 grants A (q=0x06), cycle 2 grants B (q=0x02), ops_cnt +2.
REQ-027 Same-index collision, A SET idx 5, B TOGGLE idx 5, q=0x00, rr_last=B -> A applied (q=0x20), then B toggles (q=0x00, r_strb=0x20).
REQ-028 Continuous contention from both ports for 6 cycles -> grants alternate A,B,A,B,A,B; no cycle with both ready high.
REQ-029 260 back-to-back SETs from A -> ops_cnt reaches 255 and stays 255; NOP transfers interleaved leave ops_cnt, q and strobes unchanged.
REQ-030 rst_n pulled low asynchronously mid-cycle with q=0xFF -> q=0x00, ops_cnt=0 immediately without a clock edge; contention after release grants A first.
